// File: rtl/dma_guard_pkg.sv
// ============================================================================
// Module  : dma_guard_pkg
// Brief   : Shared types and constants for the DMA guard control loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_AW    = 3'd2,
    ST_W     = 3'd3,
    ST_B     = 3'd4,
    ST_AR    = 3'd5,
    ST_R     = 3'd6,
    ST_DONE  = 3'd7
  } loader_state_t;

  localparam logic [1:0]  RESP_OKAY         = 2'b00;
  localparam logic [1:0]  RESP_SLVERR       = 2'b10;
  localparam logic [1:0]  RESP_LOCAL_ERR    = 2'b11;
  localparam logic [2:0]  AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [15:0] AXI_WSTRB_WORD    = 16'h000F;
  localparam logic [31:0] DEFAULT_META_BASE = 32'h0010_0000;
  localparam logic [31:0] DEFAULT_KEY_BASE  = 32'h0000_0000;

  // The key block holds only four words; a burst must not run past word 3.
  function automatic logic key_overrun(input logic [1:0] idx, input logic [7:0] len);
    return ({7'd0, idx} + {1'b0, len}) > 9'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_guard_beat_counter.sv
// ============================================================================
// Module  : dma_guard_beat_counter
// Brief   : Down-counter of remaining write beats with a last-beat flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_guard_beat_counter (
  input  logic       ctrl_clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] len,
  input  logic       dec,
  output logic       last
);

  logic [7:0] r_count;

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= len;
    end else if (dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign last = (r_count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/dma_guard_ctrl_loader.sv
// ============================================================================
// Module  : dma_guard_ctrl_loader
// Brief   : AXI4 initiator programming/reading the DMA guard key registers
//           and metadata window. Optional watchdog: DMA_GUARD_LOADER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_guard_ctrl_loader
  import dma_guard_pkg::*;
#(
  parameter logic [31:0] META_BASE      = DEFAULT_META_BASE,
  parameter logic [31:0] KEY_BASE       = DEFAULT_KEY_BASE,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        ctrl_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_meta,
  input  logic [17:0] cmd_index,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        done,
  output logic [1:0]  done_resp,
  output logic [31:0] ctrl_m_axi_awaddr,
  output logic [7:0]  ctrl_m_axi_awlen,
  output logic [2:0]  ctrl_m_axi_awsize,
  output logic [1:0]  ctrl_m_axi_awburst,
  output logic        ctrl_m_axi_awvalid,
  input  logic        ctrl_m_axi_awready,
  output logic        ctrl_m_axi_awlock,
  output logic [3:0]  ctrl_m_axi_awcache,
  output logic [2:0]  ctrl_m_axi_awprot,
  output logic [31:0] ctrl_m_axi_wdata,
  output logic [15:0] ctrl_m_axi_wstrb,
  output logic        ctrl_m_axi_wlast,
  output logic        ctrl_m_axi_wvalid,
  input  logic        ctrl_m_axi_wready,
  input  logic [1:0]  ctrl_m_axi_bresp,
  input  logic        ctrl_m_axi_bvalid,
  output logic        ctrl_m_axi_bready,
  output logic [31:0] ctrl_m_axi_araddr,
  output logic [7:0]  ctrl_m_axi_arlen,
  output logic [2:0]  ctrl_m_axi_arsize,
  output logic [1:0]  ctrl_m_axi_arburst,
  output logic        ctrl_m_axi_arvalid,
  input  logic        ctrl_m_axi_arready,
  output logic        ctrl_m_axi_arlock,
  output logic [3:0]  ctrl_m_axi_arcache,
  output logic [2:0]  ctrl_m_axi_arprot,
  input  logic [31:0] ctrl_m_axi_rdata,
  input  logic [1:0]  ctrl_m_axi_rresp,
  input  logic        ctrl_m_axi_rlast,
  input  logic        ctrl_m_axi_rvalid,
  output logic        ctrl_m_axi_rready
);

  loader_state_t r_state, w_state_nxt;
  logic          r_write;
  logic          r_overrun;
  logic [7:0]    r_len;
  logic [31:0]   r_addr;
  logic [1:0]    r_resp;
  logic          w_accept;
  logic          w_last;
  logic          w_wr_hs;
  logic          w_timeout;
  logic [31:0]   w_cmd_addr;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid && !reset;
  assign w_wr_hs    = (r_state == ST_W) && wr_valid && ctrl_m_axi_wready && !w_timeout;
  assign w_cmd_addr = cmd_meta ? (META_BASE | {12'd0, cmd_index, 2'b00})
                               : (KEY_BASE  | {28'd0, cmd_index[1:0], 2'b00});

  dma_guard_beat_counter u_beat_counter (
    .ctrl_clk (ctrl_clk),
    .reset    (reset),
    .load     (w_accept),
    .len      (cmd_len),
    .dec      (w_wr_hs),
    .last     (w_last)
  );

`ifdef DMA_GUARD_LOADER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              w_bus_state;
  logic              w_any_hs;

  assign w_bus_state = (r_state == ST_AW) || (r_state == ST_W) || (r_state == ST_B) ||
                       (r_state == ST_AR) || (r_state == ST_R);
  assign w_any_hs    = ((r_state == ST_AW) && ctrl_m_axi_awready) ||
                       ((r_state == ST_W)  && wr_valid && ctrl_m_axi_wready) ||
                       ((r_state == ST_B)  && ctrl_m_axi_bvalid) ||
                       ((r_state == ST_AR) && ctrl_m_axi_arready) ||
                       ((r_state == ST_R)  && ctrl_m_axi_rvalid && rd_ready);

  always_ff @(posedge ctrl_clk) begin
    if (reset || !w_bus_state || w_any_hs) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = w_bus_state && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    cmd_ready          = 1'b0;
    ctrl_m_axi_awvalid = 1'b0;
    ctrl_m_axi_wvalid  = 1'b0;
    ctrl_m_axi_wlast   = 1'b0;
    wr_ready           = 1'b0;
    ctrl_m_axi_bready  = 1'b0;
    ctrl_m_axi_arvalid = 1'b0;
    ctrl_m_axi_rready  = 1'b0;
    rd_valid           = 1'b0;
    rd_data            = 32'd0;
    rd_last            = 1'b0;
    done               = 1'b0;
    done_resp          = RESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !reset;
        if (w_accept) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_overrun)    w_state_nxt = ST_DONE;
        else if (r_write) w_state_nxt = ST_AW;
        else              w_state_nxt = ST_AR;
      end
      ST_AW: begin
        ctrl_m_axi_awvalid = 1'b1;
        if (ctrl_m_axi_awready) w_state_nxt = ST_W;
      end
      ST_W: begin
        ctrl_m_axi_wvalid = wr_valid;
        ctrl_m_axi_wlast  = w_last;
        wr_ready          = ctrl_m_axi_wready;
        if (wr_valid && ctrl_m_axi_wready && w_last) w_state_nxt = ST_B;
      end
      ST_B: begin
        ctrl_m_axi_bready = 1'b1;
        if (ctrl_m_axi_bvalid) w_state_nxt = ST_DONE;
      end
      ST_AR: begin
        ctrl_m_axi_arvalid = 1'b1;
        if (ctrl_m_axi_arready) w_state_nxt = ST_R;
      end
      ST_R: begin
        ctrl_m_axi_rready = rd_ready;
        rd_valid          = ctrl_m_axi_rvalid;
        rd_data           = ctrl_m_axi_rdata;
        rd_last           = ctrl_m_axi_rlast;
        if (ctrl_m_axi_rvalid && rd_ready && ctrl_m_axi_rlast) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        done_resp   = r_resp;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A stalled bus phase is abandoned: nothing may handshake in the same cycle.
    if (w_timeout) begin
      ctrl_m_axi_awvalid = 1'b0;
      ctrl_m_axi_wvalid  = 1'b0;
      ctrl_m_axi_wlast   = 1'b0;
      wr_ready           = 1'b0;
      ctrl_m_axi_bready  = 1'b0;
      ctrl_m_axi_arvalid = 1'b0;
      ctrl_m_axi_rready  = 1'b0;
      rd_valid           = 1'b0;
      rd_last            = 1'b0;
      w_state_nxt        = ST_DONE;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_overrun <= 1'b0;
      r_len     <= 8'd0;
      r_addr    <= 32'd0;
      r_resp    <= RESP_OKAY;
    end else begin
      if (w_accept) begin
        r_write   <= cmd_write;
        r_overrun <= !cmd_meta && key_overrun(cmd_index[1:0], cmd_len);
        r_len     <= cmd_len;
        r_addr    <= w_cmd_addr;
        r_resp    <= RESP_OKAY;
      end
      if ((r_state == ST_CHECK) && r_overrun) begin
        r_resp <= RESP_LOCAL_ERR;
      end
      if ((r_state == ST_B) && ctrl_m_axi_bvalid && !w_timeout) begin
        r_resp <= ctrl_m_axi_bresp;
      end
      // First erroring read beat wins; later beats cannot overwrite it.
      if ((r_state == ST_R) && ctrl_m_axi_rvalid && rd_ready && !w_timeout &&
          (ctrl_m_axi_rresp != RESP_OKAY) && (r_resp == RESP_OKAY)) begin
        r_resp <= ctrl_m_axi_rresp;
      end
      if (w_timeout) begin
        r_resp <= RESP_SLVERR;
      end
    end
  end

  assign ctrl_m_axi_awaddr  = r_addr;
  assign ctrl_m_axi_awlen   = r_len;
  assign ctrl_m_axi_awsize  = AXI_SIZE_4B;
  assign ctrl_m_axi_awburst = AXI_BURST_INCR;
  assign ctrl_m_axi_awlock  = 1'b0;
  assign ctrl_m_axi_awcache = 4'd0;
  assign ctrl_m_axi_awprot  = 3'd0;
  assign ctrl_m_axi_wdata   = wr_data;
  assign ctrl_m_axi_wstrb   = AXI_WSTRB_WORD;
  assign ctrl_m_axi_araddr  = r_addr;
  assign ctrl_m_axi_arlen   = r_len;
  assign ctrl_m_axi_arsize  = AXI_SIZE_4B;
  assign ctrl_m_axi_arburst = AXI_BURST_INCR;
  assign ctrl_m_axi_arlock  = 1'b0;
  assign ctrl_m_axi_arcache = 4'd0;
  assign ctrl_m_axi_arprot  = 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_dma_guard_ctrl_loader.sv
// ============================================================================
// Module  : tb_dma_guard_ctrl_loader
// Brief   : Self-checking bench with an AXI slave model and transaction-level
//           reference for dma_guard_ctrl_loader.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dma_guard_ctrl_loader;

  logic        ctrl_clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_meta;
  logic [17:0] cmd_index;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic [15:0] wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  dma_guard_ctrl_loader dut (
    .ctrl_clk(ctrl_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_meta(cmd_meta), .cmd_index(cmd_index), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .ctrl_m_axi_awaddr(awaddr), .ctrl_m_axi_awlen(awlen), .ctrl_m_axi_awsize(awsize),
    .ctrl_m_axi_awburst(awburst), .ctrl_m_axi_awvalid(awvalid), .ctrl_m_axi_awready(awready),
    .ctrl_m_axi_awlock(awlock), .ctrl_m_axi_awcache(awcache), .ctrl_m_axi_awprot(awprot),
    .ctrl_m_axi_wdata(wdata), .ctrl_m_axi_wstrb(wstrb), .ctrl_m_axi_wlast(wlast),
    .ctrl_m_axi_wvalid(wvalid), .ctrl_m_axi_wready(wready),
    .ctrl_m_axi_bresp(bresp), .ctrl_m_axi_bvalid(bvalid), .ctrl_m_axi_bready(bready),
    .ctrl_m_axi_araddr(araddr), .ctrl_m_axi_arlen(arlen), .ctrl_m_axi_arsize(arsize),
    .ctrl_m_axi_arburst(arburst), .ctrl_m_axi_arvalid(arvalid), .ctrl_m_axi_arready(arready),
    .ctrl_m_axi_arlock(arlock), .ctrl_m_axi_arcache(arcache), .ctrl_m_axi_arprot(arprot),
    .ctrl_m_axi_rdata(rdata), .ctrl_m_axi_rresp(rresp), .ctrl_m_axi_rlast(rlast),
    .ctrl_m_axi_rvalid(rvalid), .ctrl_m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic inputs_idle();
    cmd_valid = 0; cmd_write = 0; cmd_meta = 0; cmd_index = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0;
    rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
  endtask

  function automatic logic [31:0] model_addr(input logic meta, input logic [17:0] idx);
    return meta ? 32'h0010_0000 + 32'(idx) * 4 : 32'(idx % 4) * 4;
  endfunction

  function automatic logic model_overrun(input logic meta, input logic [17:0] idx, input logic [7:0] len);
    return !meta && (int'(idx % 4) + int'(len) > 3);
  endfunction

  task automatic issue_cmd(input logic wr, input logic meta, input logic [17:0] idx, input logic [7:0] len);
    int wait_cyc;
    @(negedge ctrl_clk);
    cmd_valid = 1; cmd_write = wr; cmd_meta = meta; cmd_index = idx; cmd_len = len;
    #1;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 20) begin @(negedge ctrl_clk); #1; wait_cyc++; end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge ctrl_clk);
  endtask

  task automatic post_done(input logic got_done);
    @(negedge ctrl_clk);
    inputs_idle();
    #1;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_write(input logic meta, input logic [17:0] idx, input logic [7:0] len,
                          input int gap, input int aw_delay, input int b_delay,
                          input logic [1:0] bresp_v, input int rst_beat);
    logic [31:0] data_q[$];
    logic [31:0] exp_addr;
    logic        exp_err, aw_done, got_done, toggle, do_rst;
    logic [1:0]  exp_resp;
    int          sent, aw_seen, b_seen, cyc, budget;
    exp_addr = model_addr(meta, idx);
    exp_err  = model_overrun(meta, idx, len);
    exp_resp = exp_err ? 2'b11 : bresp_v;
`ifdef DMA_GUARD_LOADER_TIMEOUT_EN
    if (!exp_err && b_delay >= 1024) exp_resp = 2'b10;
`endif
    for (int i = 0; i <= int'(len); i++) data_q.push_back($urandom);
    issue_cmd(1'b1, meta, idx, len);
    cyc = 0; sent = 0; aw_seen = 0; b_seen = 0;
    aw_done = 0; got_done = 0; toggle = 0; do_rst = 0;
    budget = 64 + 8 * int'(len) + aw_delay + b_delay;
    while (!got_done && cyc < budget) begin
      @(negedge ctrl_clk);
      cyc++;
      cmd_valid = 0;
      if (rst_beat >= 0 && sent == rst_beat) begin reset = 1; do_rst = 1; end
      #1;
      if (exp_err) chk("no_aw_on_err", 32'(awvalid), 32'd0);
      if (aw_seen > 0 && !aw_done) chk("awvalid_held", 32'(awvalid), 32'd1);
      if (awvalid) begin
        chk("awaddr", awaddr, exp_addr);
        chk("awlen", 32'(awlen), 32'(len));
        chk("aw_size_burst", 32'({awsize, awburst}), 32'({3'b010, 2'b01}));
        awready = (aw_seen >= aw_delay);
        aw_seen++;
      end else awready = 0;
      toggle   = ~toggle;
      wr_valid = (sent <= int'(len)) && (gap == 0 || toggle);
      wr_data  = (sent <= int'(len)) ? data_q[sent] : 32'd0;
      wready   = (gap == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (bready) begin
        bvalid = (b_seen >= b_delay);
        bresp  = bresp_v;
        b_seen++;
      end else bvalid = 0;
      #1;
      if (wvalid) chk("w_after_aw", 32'(aw_done), 32'd1);
      if (wr_valid && wr_ready) begin
        chk("wvalid_mirror", 32'(wvalid), 32'd1);
        chk("wdata", wdata, data_q[sent]);
        chk("wlast", 32'(wlast), 32'(sent == int'(len)));
        chk("wstrb", 32'(wstrb), 32'h000F);
        sent++;
      end
      if (awvalid && awready) aw_done = 1;
      if (done) begin
        got_done = 1;
        chk("done_resp", 32'(done_resp), 32'(exp_resp));
      end
      if (do_rst) break;
    end
    if (do_rst) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge ctrl_clk);
        inputs_idle();
        #1;
        chk("reset_quiet", 32'({cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid,
                                rready, rd_valid, rd_last, done}), 32'd0);
      end
      chk("no_done_before_reset", 32'(got_done), 32'd0);
      @(negedge ctrl_clk);
      reset = 0;
    end else begin
      chk("write_beats", 32'(sent), exp_err ? 32'd0 : 32'(int'(len) + 1));
      if (gap == 0 && aw_delay == 0 && b_delay == 0)
        chk("write_latency", 32'(cyc), exp_err ? 32'd2 : 32'(int'(len) + 5));
      post_done(got_done);
    end
  endtask

  task automatic do_read(input logic meta, input logic [17:0] idx, input logic [7:0] len,
                         input int ar_delay, input int err_mode, input int bp);
    logic [31:0] data_q[$];
    logic [1:0]  resp_q[$];
    logic [31:0] exp_addr;
    logic        exp_err, ar_done, got_done;
    logic [1:0]  exp_resp;
    int          k, ar_seen, cyc, budget;
    exp_addr = model_addr(meta, idx);
    exp_err  = model_overrun(meta, idx, len);
    for (int i = 0; i <= int'(len); i++) begin
      data_q.push_back($urandom);
      if (err_mode == 0)      resp_q.push_back(2'b00);
      else if (err_mode == 1) resp_q.push_back(i == 0 ? 2'b10 : 2'b00);
      else                    resp_q.push_back($urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b00);
    end
    exp_resp = 2'b00;
    foreach (resp_q[i]) if (exp_resp == 2'b00) exp_resp = resp_q[i];
    if (exp_err) exp_resp = 2'b11;
    issue_cmd(1'b0, meta, idx, len);
    cyc = 0; k = 0; ar_seen = 0; ar_done = 0; got_done = 0;
    budget = 64 + 8 * int'(len) + ar_delay;
    while (!got_done && cyc < budget) begin
      @(negedge ctrl_clk);
      cyc++;
      cmd_valid = 0;
      #1;
      chk("no_aw_on_read", 32'(awvalid), 32'd0);
      if (exp_err) chk("no_ar_on_err", 32'(arvalid), 32'd0);
      if (arvalid) begin
        chk("araddr", araddr, exp_addr);
        chk("arlen", 32'(arlen), 32'(len));
        chk("ar_size_burst", 32'({arsize, arburst}), 32'({3'b010, 2'b01}));
        arready = (ar_seen >= ar_delay);
        ar_seen++;
      end else arready = 0;
      rvalid   = ar_done && (k <= int'(len)) && (bp == 0 || $urandom_range(0, 1) == 1);
      rdata    = (k <= int'(len)) ? data_q[k] : 32'd0;
      rresp    = (k <= int'(len)) ? resp_q[k] : 2'b00;
      rlast    = (k == int'(len));
      rd_ready = (bp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (rd_valid) chk("rready_mirror", 32'(rready), 32'(rd_ready));
      if (rvalid && rready) begin
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, data_q[k]);
        chk("rd_last", 32'(rd_last), 32'(k == int'(len)));
        k++;
      end
      if (arvalid && arready) ar_done = 1;
      if (done) begin
        got_done = 1;
        chk("done_resp", 32'(done_resp), 32'(exp_resp));
      end
    end
    chk("read_beats", 32'(k), exp_err ? 32'd0 : 32'(int'(len) + 1));
    if (bp == 0 && ar_delay == 0)
      chk("read_latency", 32'(cyc), exp_err ? 32'd2 : 32'(int'(len) + 4));
    post_done(got_done);
  endtask

  initial begin
    logic        meta;
    logic [17:0] idx;
    logic [7:0]  len;
    reset = 1;
    inputs_idle();
    repeat (2) @(negedge ctrl_clk);
    #1;
    chk("reset_quiet", 32'({cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid,
                            rready, rd_valid, rd_last, done}), 32'd0);
    chk("reset_done_resp", 32'(done_resp), 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_lens", 32'({awlen, arlen}), 32'd0);
    chk("tied_attrs", 32'({awlock, awcache, awprot, arlock, arcache, arprot}), 32'd0);
    @(negedge ctrl_clk);
    reset = 0;

    do_write(1'b0, 18'd0, 8'd3, 0, 0, 0, 2'b00, -1);
    do_read(1'b1, 18'h10, 8'd1, 0, 0, 0);
    do_write(1'b0, 18'd2, 8'd3, 0, 0, 0, 2'b00, -1);
    do_write(1'b1, 18'h3_0001, 8'd5, 1, 5, 0, 2'b00, -1);
    do_read(1'b1, 18'h22, 8'd2, 0, 1, 0);
    do_read(1'b0, 18'd3, 8'd1, 0, 0, 0);
    do_write(1'b0, 18'd3, 8'd0, 0, 0, 2, 2'b10, -1);

    for (int t = 0; t < 12; t++) begin
      meta = 1'($urandom);
      idx  = 18'($urandom);
      len  = meta ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(meta, idx, len, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 2'($urandom), -1);
      else
        do_read(meta, idx, len, int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 1)));
    end

    do_write(1'b1, 18'd7, 8'd3, 0, 0, 0, 2'b00, 1);
    do_write(1'b1, 18'd8, 8'd2, 0, 0, 0, 2'b00, -1);
`ifdef DMA_GUARD_LOADER_TIMEOUT_EN
    do_write(1'b1, 18'd3, 8'd1, 0, 0, 2000, 2'b00, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
